// File: rtl/ahb_arbiter_burst_rr.sv
// Per-slave AHB arbiter: fixed-priority or round-robin selection, holds the grant
// for a whole burst and flags the beat that ends each transaction.
module ahb_arbiter_burst_rr #(
  parameter int MASTER_NUM     = 4,
  parameter int MODE           = 0,
  parameter int INCR_MAX_BEATS = 16,
  parameter int MIDX_W         = $clog2(MASTER_NUM)
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic [MASTER_NUM-1:0]   hreq,
  input  logic [MASTER_NUM*3-1:0] hburst,
  input  logic                    hwait,
  output logic [MASTER_NUM-1:0]   hgrant,
  output logic                    hsel,
  output logic [MIDX_W-1:0]       hmaster,
  output logic                    hlast
);

  localparam int CNT_W = ($clog2(INCR_MAX_BEATS) > 4) ? $clog2(INCR_MAX_BEATS) : 4;
  localparam logic [CNT_W-1:0] INCR_LIMIT = CNT_W'(INCR_MAX_BEATS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
  typedef enum logic [2:0] {
    SINGLE = 3'd0, INCR = 3'd1, WRAP4 = 3'd2, INCR4 = 3'd3,
    WRAP8  = 3'd4, INCR8 = 3'd5, WRAP16 = 3'd6, INCR16 = 3'd7
  } burst_t;

  state_t            state;
  burst_t            burst;
  burst_t            win_burst;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  limit;
  logic [MIDX_W-1:0] rr_ptr;
  logic [MIDX_W-1:0] winner;
  logic [MIDX_W-1:0] idx;
  logic [MIDX_W-1:0] next_ptr;
  logic              accept;
  logic              owner_req;

  // Descending scans so the last hit (lowest index / smallest offset) wins.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    winner = '0;
    idx    = '0;
    if (MODE == 0) begin
      for (int i = MASTER_NUM - 1; i >= 0; i--)
        if (hreq[i]) winner = MIDX_W'(i);
    end else begin
      for (int k = MASTER_NUM - 1; k >= 0; k--) begin
        idx = MIDX_W'((int'(rr_ptr) + k) % MASTER_NUM);
        if (hreq[idx]) winner = idx;
      end
    end
  end

  always_comb begin
    win_burst = SINGLE;
    for (int i = 0; i < MASTER_NUM; i++)
      if (winner == MIDX_W'(i)) win_burst = burst_t'(hburst[3*i +: 3]);
  end

  always_comb begin
    limit = '0;
    case (burst)
      SINGLE:        limit = '0;
      INCR:          limit = INCR_LIMIT;
      WRAP4, INCR4:  limit = CNT_W'(3);
      WRAP8, INCR8:  limit = CNT_W'(7);
      default:       limit = CNT_W'(15);
    endcase
  end

  assign owner_req = hreq[hmaster];
  assign accept    = (state == BUSY) && !hwait;
  // An INCR owner releasing its request turns the current beat into the final one.
  assign hlast     = accept && ((beat_cnt == limit) || ((burst == INCR) && !owner_req));
  assign hsel      = |hgrant;
  assign next_ptr  = (hmaster == MIDX_W'(MASTER_NUM - 1)) ? '0 : hmaster + 1'b1;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state    <= IDLE;
      hgrant   <= '0;
      hmaster  <= '0;
      burst    <= SINGLE;
      beat_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      case (state)
        IDLE: if (|hreq) begin
          hgrant   <= MASTER_NUM'(1) << winner;
          hmaster  <= winner;
          burst    <= win_burst;
          beat_cnt <= '0;
          state    <= BUSY;
        end
        BUSY: if (hlast) begin
          hgrant   <= '0;
          hmaster  <= '0;
          beat_cnt <= '0;
          state    <= GAP;
          if (MODE == 1) rr_ptr <= next_ptr;
        end else if (accept) begin
          beat_cnt <= beat_cnt + 1'b1;
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  a_grant_onehot: assert property (@(posedge hclk) $onehot0(hgrant));
  a_last_has_sel: assert property (@(posedge hclk) hlast |-> hsel);
  a_grant_stable: assert property (@(posedge hclk) disable iff (hreset)
                                   (state == BUSY && !hlast) |=> (hgrant == $past(hgrant)));

endmodule

// File: tb/tb_ahb_arbiter_burst_rr.sv
// Bench for ahb_arbiter_burst_rr: a fixed-priority and a round-robin instance share
// stimulus; grant starts are matched against an expected-grant queue per instance.
module tb_ahb_arbiter_burst_rr;

  localparam int N = 4;

  typedef struct packed {
    logic [N-1:0] grant;
    logic [1:0]   midx;
  } exp_t;

  logic         hclk = 1'b0;
  logic         hreset;
  logic [N-1:0] hreq;
  logic [3*N-1:0] hburst;
  logic         hwait;

  logic [N-1:0] fp_hgrant, rr_hgrant;
  logic         fp_hsel, rr_hsel;
  logic [1:0]   fp_hmaster, rr_hmaster;
  logic         fp_hlast, rr_hlast;

  int   total = 0;
  int   bad   = 0;
  exp_t q_fp[$];
  exp_t q_rr[$];
  logic mon_fp = 1'b0, mon_rr = 1'b0;
  logic fp_prev = 1'b0, rr_prev = 1'b0;

  always #5 hclk = ~hclk;

  ahb_arbiter_burst_rr #(.MASTER_NUM(N), .MODE(0), .INCR_MAX_BEATS(16)) u_fp (
    .hclk(hclk), .hreset(hreset), .hreq(hreq), .hburst(hburst), .hwait(hwait),
    .hgrant(fp_hgrant), .hsel(fp_hsel), .hmaster(fp_hmaster), .hlast(fp_hlast)
  );

  ahb_arbiter_burst_rr #(.MASTER_NUM(N), .MODE(1), .INCR_MAX_BEATS(16)) u_rr (
    .hclk(hclk), .hreset(hreset), .hreq(hreq), .hburst(hburst), .hwait(hwait),
    .hgrant(rr_hgrant), .hsel(rr_hsel), .hmaster(rr_hmaster), .hlast(rr_hlast)
  );

  function automatic exp_t mk(input logic [N-1:0] g, input logic [1:0] m);
    mk.grant = g;
    mk.midx  = m;
  endfunction

  // Scoreboard: every rising hsel must match the next queued expected grant.
  always @(negedge hclk) begin : monitor
    exp_t e;
    if (mon_fp && fp_hsel && !fp_prev) begin
      total++;
      if (q_fp.size() == 0) begin
        bad++;
        $display("FAIL sb_fp_unexpected: got hgrant=%b hmaster=%0d, required no grant", fp_hgrant, fp_hmaster);
      end else begin
        e = q_fp.pop_front();
        if ({fp_hgrant, fp_hmaster} !== {e.grant, e.midx}) begin
          bad++;
          $display("FAIL sb_fp_grant: got hgrant=%b hmaster=%0d, required hgrant=%b hmaster=%0d",
                   fp_hgrant, fp_hmaster, e.grant, e.midx);
        end
      end
    end
    if (mon_rr && rr_hsel && !rr_prev) begin
      total++;
      if (q_rr.size() == 0) begin
        bad++;
        $display("FAIL sb_rr_unexpected: got hgrant=%b hmaster=%0d, required no grant", rr_hgrant, rr_hmaster);
      end else begin
        e = q_rr.pop_front();
        if ({rr_hgrant, rr_hmaster} !== {e.grant, e.midx}) begin
          bad++;
          $display("FAIL sb_rr_grant: got hgrant=%b hmaster=%0d, required hgrant=%b hmaster=%0d",
                   rr_hgrant, rr_hmaster, e.grant, e.midx);
        end
      end
    end
    fp_prev = fp_hsel;
    rr_prev = rr_hsel;
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic do_reset();
    hreset = 1'b1;
    hreq   = '0;
    hburst = '0;
    hwait  = 1'b0;
    tick();
    tick();
    hreset = 1'b0;
  endtask

  task automatic drain(input string name);
    total++;
    if (q_fp.size() + q_rr.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: got %0d grants still expected, required 0", name, q_fp.size() + q_rr.size());
    end
    q_fp.delete();
    q_rr.delete();
    mon_fp = 1'b0;
    mon_rr = 1'b0;
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    hreq   = 4'b1111;
    hburst = '0;
    hwait  = 1'b0;
    tick();
    tick();
    @(negedge hclk);
    total++;
    if ({fp_hgrant, fp_hsel, fp_hmaster, fp_hlast, u_fp.beat_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_fp: got hgrant=%b hsel=%b hmaster=%0d hlast=%b cnt=%0d, required all 0",
               fp_hgrant, fp_hsel, fp_hmaster, fp_hlast, u_fp.beat_cnt);
    end
    total++;
    if ({rr_hgrant, rr_hsel, rr_hmaster, rr_hlast, u_rr.beat_cnt, u_rr.rr_ptr} !== '0) begin
      bad++;
      $display("FAIL reset_rr: got hgrant=%b hsel=%b hmaster=%0d cnt=%0d ptr=%0d, required all 0",
               rr_hgrant, rr_hsel, rr_hmaster, u_rr.beat_cnt, u_rr.rr_ptr);
    end
    tick();
    hreset = 1'b0;
    hreq   = '0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    mon_fp = 1'b1;
    hreq   = 4'b0100;
    q_fp.push_back(mk(4'b0100, 2'd2));
    @(negedge hclk);
    total++;
    if (fp_hgrant !== 4'b0000) begin
      bad++;
      $display("FAIL single_latency: got hgrant=%b, required 0000", fp_hgrant);
    end
    tick();
    hreq = '0;
    @(negedge hclk);
    total++;
    if ({fp_hgrant, fp_hmaster, fp_hlast} !== {4'b0100, 2'd2, 1'b1}) begin
      bad++;
      $display("FAIL single_beat: got hgrant=%b hmaster=%0d hlast=%b, required 0100 2 1",
               fp_hgrant, fp_hmaster, fp_hlast);
    end
    tick();
    @(negedge hclk);
    total++;
    if ({fp_hgrant, fp_hsel} !== 5'b0) begin
      bad++;
      $display("FAIL single_gap: got hgrant=%b hsel=%b, required 0000 0", fp_hgrant, fp_hsel);
    end
    tick();
    drain("single");
  endtask

  task automatic test_wait_incr4();
    logic [5:0] w;
    int         exp_cnt [6];
    w       = 6'b001100;
    exp_cnt = '{0, 1, 2, 2, 2, 3};
    do_reset();
    mon_fp = 1'b1;
    hburst[2:0] = 3'd3;
    hreq = 4'b0001;
    q_fp.push_back(mk(4'b0001, 2'd0));
    @(negedge hclk);
    tick();
    for (int c = 0; c < 6; c++) begin
      hwait = w[c];
      hreq  = (c == 0) ? 4'b0001 : 4'b0000;
      @(negedge hclk);
      total++;
      if ({fp_hgrant, fp_hlast, u_fp.beat_cnt} !== {4'b0001, (c == 5), 4'(exp_cnt[c])}) begin
        bad++;
        $display("FAIL incr4_cycle%0d: got hgrant=%b hlast=%b cnt=%0d, required 0001 %b %0d",
                 c, fp_hgrant, fp_hlast, u_fp.beat_cnt, (c == 5), exp_cnt[c]);
      end
      tick();
    end
    hwait = 1'b0;
    @(negedge hclk);
    total++;
    if (fp_hgrant !== 4'b0000) begin
      bad++;
      $display("FAIL incr4_end: got hgrant=%b, required 0000", fp_hgrant);
    end
    tick();
    drain("incr4");
  endtask

  task automatic test_fixed_priority();
    logic [N-1:0] eg;
    do_reset();
    mon_fp = 1'b1;
    hreq   = 4'b1010;
    for (int i = 0; i < 4; i++) q_fp.push_back(mk(4'b0010, 2'd1));
    for (int k = 0; k < 12; k++) begin
      @(negedge hclk);
      eg = (k % 3 == 1) ? 4'b0010 : 4'b0000;
      total++;
      if (fp_hgrant !== eg) begin
        bad++;
        $display("FAIL fixed_prio_cycle%0d: got hgrant=%b, required %b", k, fp_hgrant, eg);
      end
      tick();
    end
    hreq = '0;
    tick();
    tick();
    drain("fixed_prio");
  endtask

  task automatic test_round_robin();
    logic [N-1:0] eg;
    logic [1:0]   ep;
    do_reset();
    mon_rr = 1'b1;
    hreq   = 4'b1111;
    for (int i = 0; i < 5; i++) q_rr.push_back(mk(4'(1 << (i % 4)), 2'(i % 4)));
    for (int k = 0; k < 15; k++) begin
      @(negedge hclk);
      eg = (k % 3 == 1) ? 4'(1 << (((k - 1) / 3) % 4)) : 4'b0000;
      total++;
      if (rr_hgrant !== eg) begin
        bad++;
        $display("FAIL rr_cycle%0d: got hgrant=%b, required %b", k, rr_hgrant, eg);
      end
      if (k % 3 == 2) begin
        ep = 2'((((k - 2) / 3) + 1) % 4);
        total++;
        if (u_rr.rr_ptr !== ep) begin
          bad++;
          $display("FAIL rr_ptr_cycle%0d: got ptr=%0d, required %0d", k, u_rr.rr_ptr, ep);
        end
      end
      tick();
    end
    hreq = '0;
    tick();
    tick();
    drain("rr");
  endtask

  task automatic test_incr_hold();
    do_reset();
    mon_fp = 1'b1;
    hburst[11:9] = 3'd1;
    hreq = 4'b1000;
    q_fp.push_back(mk(4'b1000, 2'd3));
    @(negedge hclk);
    tick();
    for (int c = 0; c < 5; c++) begin
      hreq = (c == 4) ? 4'b0000 : 4'b1000;
      @(negedge hclk);
      total++;
      if ({fp_hgrant, fp_hlast} !== {4'b1000, (c == 4)}) begin
        bad++;
        $display("FAIL incr_drop_beat%0d: got hgrant=%b hlast=%b, required 1000 %b", c, fp_hgrant, fp_hlast, (c == 4));
      end
      tick();
    end
    @(negedge hclk);
    total++;
    if (fp_hgrant !== 4'b0000) begin
      bad++;
      $display("FAIL incr_drop_gap: got hgrant=%b, required 0000", fp_hgrant);
    end
    tick();
    hreq = 4'b1000;
    q_fp.push_back(mk(4'b1000, 2'd3));
    @(negedge hclk);
    tick();
    for (int c = 0; c < 16; c++) begin
      @(negedge hclk);
      total++;
      if ({fp_hgrant, fp_hlast, u_fp.beat_cnt} !== {4'b1000, (c == 15), 4'(c)}) begin
        bad++;
        $display("FAIL incr_cap_beat%0d: got hgrant=%b hlast=%b cnt=%0d, required 1000 %b %0d",
                 c, fp_hgrant, fp_hlast, u_fp.beat_cnt, (c == 15), c);
      end
      tick();
    end
    hreq = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge hclk);
      total++;
      if (fp_hgrant !== 4'b0000) begin
        bad++;
        $display("FAIL incr_cap_after%0d: got hgrant=%b, required 0000", c, fp_hgrant);
      end
      tick();
    end
    drain("incr");
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    mon_rr = 1'b1;
    hburst[8:6] = 3'd0;
    hburst[5:3] = 3'd5;
    hreq = 4'b0100;
    q_rr.push_back(mk(4'b0100, 2'd2));
    @(negedge hclk);
    tick();
    hreq = '0;
    @(negedge hclk);
    tick();
    @(negedge hclk);
    total++;
    if (u_rr.rr_ptr !== 2'd3) begin
      bad++;
      $display("FAIL midrst_ptr_pre: got ptr=%0d, required 3", u_rr.rr_ptr);
    end
    tick();
    hreq = 4'b0010;
    q_rr.push_back(mk(4'b0010, 2'd1));
    @(negedge hclk);
    tick();
    for (int c = 0; c < 3; c++) begin
      if (c == 2) hreset = 1'b1;
      @(negedge hclk);
      total++;
      if ({rr_hgrant, u_rr.beat_cnt} !== {4'b0010, 4'(c)}) begin
        bad++;
        $display("FAIL midrst_beat%0d: got hgrant=%b cnt=%0d, required 0010 %0d", c, rr_hgrant, u_rr.beat_cnt, c);
      end
      tick();
    end
    hreset = 1'b0;
    hreq   = 4'b0100;
    q_rr.push_back(mk(4'b0100, 2'd2));
    @(negedge hclk);
    total++;
    if ({rr_hgrant, rr_hsel, rr_hmaster, u_rr.beat_cnt, u_rr.rr_ptr} !== '0) begin
      bad++;
      $display("FAIL midrst_state: got hgrant=%b hsel=%b hmaster=%0d cnt=%0d ptr=%0d, required all 0",
               rr_hgrant, rr_hsel, rr_hmaster, u_rr.beat_cnt, u_rr.rr_ptr);
    end
    tick();
    hreq = '0;
    @(negedge hclk);
    total++;
    if ({rr_hgrant, rr_hmaster} !== {4'b0100, 2'd2}) begin
      bad++;
      $display("FAIL midrst_regrant: got hgrant=%b hmaster=%0d, required 0100 2", rr_hgrant, rr_hmaster);
    end
    tick();
    tick();
    drain("midrst");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    hreset = 1'b1;
    hreq   = '0;
    hburst = '0;
    hwait  = 1'b0;
    #1;
    test_reset();
    test_single();
    test_wait_incr4();
    test_fixed_priority();
    test_round_robin();
    test_incr_hold();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
